// File: rtl/lii_tx_packer.sv
// Packs DW-bit kernel words into PW-bit LII phy beats tagged with static src/dst IDs; drives kernel ce.
// Latency: completing word accepted at edge N -> beat valid after edge N; 1 word/clk sustained.
// Backpressure: s_tready/ce drop only when the beat-completing word meets a held, non-draining beat.
// Optional feature macro LII_TX_FLUSH_EN: s_tlast closes a beat early (upper lanes zero) and sets lii_out_p0_tlast.
module lii_tx_packer #(
  parameter int          DW     = 32,
  parameter int          PW     = 128,
  parameter logic [7:0]  SRC_ID = 8'h00,
  parameter logic [7:0]  DST_ID = 8'h01
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
`ifdef LII_TX_FLUSH_EN
  input  logic          s_tlast,
  output logic          lii_out_p0_tlast,
`endif
  output logic [PW-1:0] lii_out_p0_tdata,
  output logic          lii_out_p0_tvalid,
  input  logic          lii_out_p0_tready,
  output logic [7:0]    lii_out_p0_src,
  output logic [7:0]    lii_out_p0_dst,
  output logic          ce
);

  localparam int RATIO = PW / DW;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  generate
    if ((PW % DW) != 0) begin : g_bad_width
      $error("lii_tx_packer: PW must be an integer multiple of DW");
    end
  endgenerate

  // Accumulator is kept PW wide so the completing word can be OR-ed straight in;
  // the top lane is never written on a non-completing accept and so stays zero.
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] out_q, out_d;
  logic          vld_q, vld_d;
  logic          tlast_q, tlast_d;

  logic          in_last;
  logic          at_last_lane;
  logic          accept;
  logic          drain;
  logic          complete;
  logic [PW-1:0] lane_ins;

`ifdef LII_TX_FLUSH_EN
  assign in_last = s_tlast;
`else
  assign in_last = 1'b0;
`endif

  assign at_last_lane = (cnt_q == LAST_LANE);
  assign drain        = vld_q & lii_out_p0_tready;
  // Stall only when this word would close a beat while the previous one is still held.
  assign s_tready     = ~arst & ~(vld_q & ~lii_out_p0_tready & (at_last_lane | in_last));
  assign accept       = s_tvalid & s_tready;
  assign complete     = accept & (at_last_lane | in_last);

  // Place the incoming word on the lane selected by the lane counter; other lanes zero.
  always_comb begin
    lane_ins = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) begin
        lane_ins[i*DW +: DW] = s_tdata;
      end
    end
  end

  // Next-state: accumulate lanes, load the output register on completion, clear on drain.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    tlast_d = tlast_q;
    if (drain) begin
      vld_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        out_d   = acc_q | lane_ins;
        vld_d   = 1'b1;
        tlast_d = in_last;
        cnt_d   = '0;
        acc_d   = '0;
      end else begin
        acc_d = acc_q | lane_ins;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset drops any partial or held beat.
  always_ff @(posedge aclk) begin
    if (arst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      tlast_q <= tlast_d;
    end
  end

  assign lii_out_p0_tdata  = out_q;
  assign lii_out_p0_tvalid = vld_q;
  assign lii_out_p0_src    = SRC_ID;
  assign lii_out_p0_dst    = DST_ID;
  assign ce                = s_tready;
`ifdef LII_TX_FLUSH_EN
  assign lii_out_p0_tlast  = tlast_q;
`endif

endmodule

// File: tb/tb_lii_tx_packer.sv
// Bench for lii_tx_packer (DW=32, PW=128): directed scenarios plus random traffic
// checked against a word-list reference model of the packing rules.
module tb_lii_tx_packer;

  localparam int DW    = 32;
  localparam int PW    = 128;
  localparam int RATIO = PW / DW;
`ifdef LII_TX_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          arst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [PW-1:0] lii_out_p0_tdata;
  logic          lii_out_p0_tvalid;
  logic          lii_out_p0_tready;
  logic [7:0]    lii_out_p0_src;
  logic [7:0]    lii_out_p0_dst;
  logic          lii_out_p0_tlast;
  logic          ce;

  lii_tx_packer #(.DW(DW), .PW(PW), .SRC_ID(8'h00), .DST_ID(8'h01)) dut (
    .aclk              (aclk),
    .arst              (arst),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
`ifdef LII_TX_FLUSH_EN
    .s_tlast           (s_tlast),
    .lii_out_p0_tlast  (lii_out_p0_tlast),
`endif
    .lii_out_p0_tdata  (lii_out_p0_tdata),
    .lii_out_p0_tvalid (lii_out_p0_tvalid),
    .lii_out_p0_tready (lii_out_p0_tready),
    .lii_out_p0_src    (lii_out_p0_src),
    .lii_out_p0_dst    (lii_out_p0_dst),
    .ce                (ce)
  );

`ifndef LII_TX_FLUSH_EN
  assign lii_out_p0_tlast = 1'b0;
`endif

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: words waiting to form a beat, and beats offered to the fabric.
  logic [DW-1:0] words[$];
  logic [PW-1:0] exp_beats[$];
  bit            exp_lasts[$];
  logic [PW-1:0] dut_last_beat;
  bit            dut_last_tlast;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model
  // by what the next rising edge will transfer.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                      input logic rst, input logic last);
    logic exp_rdy;
    logic [PW-1:0] beat;
    @(negedge aclk);
    s_tvalid = v; s_tdata = d; lii_out_p0_tready = rdy; arst = rst; s_tlast = last;
    #1;
    exp_rdy = !rst && !(exp_beats.size() > 0 && !rdy &&
                        (words.size() == RATIO - 1 || (FLUSH && last)));
    check("s_tready", PW'(s_tready), PW'(exp_rdy));
    check("ce", PW'(ce), PW'(exp_rdy));
    check("tvalid", PW'(lii_out_p0_tvalid), PW'(exp_beats.size() > 0));
    if (exp_beats.size() > 0) begin
      check("tdata", lii_out_p0_tdata, exp_beats[0]);
      if (FLUSH) check("tlast", PW'(lii_out_p0_tlast), PW'(exp_lasts[0]));
    end
    if (rst) begin
      words.delete(); exp_beats.delete(); exp_lasts.delete();
    end else begin
      if (exp_beats.size() > 0 && rdy) begin
        dut_last_beat  = lii_out_p0_tdata;
        dut_last_tlast = lii_out_p0_tlast;
        void'(exp_beats.pop_front());
        void'(exp_lasts.pop_front());
      end
      if (v && exp_rdy) begin
        words.push_back(d);
        if (words.size() == RATIO || (FLUSH && last)) begin
          beat = '0;
          foreach (words[i]) beat[i*DW +: DW] = words[i];
          exp_beats.push_back(beat);
          exp_lasts.push_back(FLUSH && last);
          words.delete();
        end
      end
    end
  endtask

  initial begin
    arst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; lii_out_p0_tready = 1'b0;
    dut_last_beat = '0; dut_last_tlast = 1'b0;
    @(negedge aclk); @(negedge aclk);
    // Reset state: ready held low during reset, nothing valid, constant IDs.
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("src", PW'(lii_out_p0_src), PW'(8'h00));
    check("dst", PW'(lii_out_p0_dst), PW'(8'h01));

    // Four words back-to-back -> one beat, visible the cycle after the 4th accept.
    step(1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h33333333, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h44444444, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t1_beat", dut_last_beat, 128'h44444444_33333333_22222222_11111111);

    // Eight continuous words, fabric always ready -> no stall cycles.
    for (int i = 0; i < 8; i++) step(1'b1, 32'hC0DE_0000 + i, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Held beat: 4 words fill it, 3 more accepted, 4th stalls, then released same edge.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB100_0000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB100_0003, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB100_0003, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t3_beat", dut_last_beat, 128'hB1000003_B1000002_B1000001_B1000000);

    // Reset mid-accumulation: partial beat discarded, next beat clean.
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hFEEDFACE, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000000A, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000000B, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000000C, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000000D, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t4_beat", dut_last_beat, 128'h0000000D_0000000C_0000000B_0000000A);

    // Ready rises in the same cycle as the completing word of the next beat.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h6100_0000 + i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h6100_0003, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t6_beat", dut_last_beat, 128'h61000003_61000002_61000001_61000000);

    if (FLUSH) begin
      step(1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h22222222, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("t5_beat", dut_last_beat, 128'h00000000_00000000_22222222_11111111);
      check("t5_tlast", PW'(dut_last_tlast), PW'(1'b1));
      for (int i = 0; i < 4; i++) step(1'b1, 32'h5000_0000 + i, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("t5_full_tlast", PW'(dut_last_tlast), PW'(1'b0));
    end

    // Random traffic with random backpressure, flushes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 5) == 0));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
